// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback_queue
//  Purpose  : In-order write-back FIFO feeding the 64-bit x 32 register file
//             write port, with two combinational lookup ports that report the
//             youngest pending value for a source register.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [63:0]              in_data,
    input  logic                     wb_stall,
    output logic                     RegWrite,
    output logic [4:0]               RD,
    output logic [63:0]              WriteData,
    input  logic [4:0]               lk_rs1,
    input  logic [4:0]               lk_rs2,
    output logic                     lk_hit1,
    output logic                     lk_hit2,
    output logic [63:0]              lk_data1,
    output logic [63:0]              lk_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [4:0]         r_rd   [DEPTH];
    logic [63:0]        r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push;
    logic               w_store;
    logic               w_pop;
    logic               w_nonEmpty;
    logic [c_PTR_W-1:0] w_slot [DEPTH];

    // Handshake completes whenever there is room; an x0 result is accepted
    // but never stored when DROP_X0 is set, since writing x0 has no effect.
    assign w_nonEmpty = (r_count != '0);
    assign in_ready   = (r_count != c_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_store    = w_push && !(DROP_X0 && (in_rd == 5'd0));

    // Head entry is presented whenever the queue is non-empty; stall only
    // gates the write enable, not the address/data.
    assign RegWrite  = w_nonEmpty && !wb_stall;
    assign w_pop     = RegWrite;
    assign RD        = w_nonEmpty ? r_rd[r_head]   : 5'd0;
    assign WriteData = w_nonEmpty ? r_data[r_head] : 64'd0;
    assign count     = r_count;

    // Physical slot of the i-th oldest entry (pointers wrap modulo DEPTH).
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            assign w_slot[k] = r_head + c_PTR_W'(k);
        end
    endgenerate

    // Pointer and occupancy update; reset wins over any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop)   r_head <= r_head + c_PTR_W'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (reset && w_store) begin
            r_rd[r_tail]   <= in_rd;
            r_data[r_tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        lk_hit1  = 1'b0;
        lk_hit2  = 1'b0;
        lk_data1 = 64'd0;
        lk_data2 = 64'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_CNT_W'(i) < r_count) begin
                if (r_rd[w_slot[i]] == lk_rs1 && !(DROP_X0 && (lk_rs1 == 5'd0))) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = r_data[w_slot[i]];
                end
                if (r_rd[w_slot[i]] == lk_rs2 && !(DROP_X0 && (lk_rs2 == 5'd0))) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = r_data[w_slot[i]];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_writeback_queue
//  Purpose  : Self-checking bench for regfile_writeback_queue: directed
//             vector table, hand-written corner sequences and randomized
//             traffic checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;

    localparam int c_DEPTH   = 4;
    localparam bit c_DROP_X0 = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [63:0] in_data;
    logic        wb_stall;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [4:0]  lk_rs1;
    logic [4:0]  lk_rs2;
    logic        lk_hit1;
    logic        lk_hit2;
    logic [63:0] lk_data1;
    logic [63:0] lk_data2;
    logic [2:0]  count;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: pending writes, oldest at index 0.
    logic [4:0]  mRd[$];
    logic [63:0] mData[$];

    regfile_writeback_queue #(.DEPTH(c_DEPTH), .DROP_X0(c_DROP_X0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .lk_rs1(lk_rs1), .lk_rs2(lk_rs2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
        .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        stall;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        eRw;
        logic [4:0]  eRd;
        logic [63:0] eWd;
        logic        eRdy;
        logic [2:0]  eCnt;
        logic        eH1;
        logic [63:0] eD1;
        logic        eH2;
        logic [63:0] eD2;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [4:0] rd,
                         input logic [63:0] d, input logic st,
                         input logic [4:0] l1, input logic [4:0] l2);
        reset = rst; in_valid = v; in_rd = rd; in_data = d;
        wb_stall = st; lk_rs1 = l1; lk_rs2 = l2;
    endtask

    // Youngest pending value for a source register, straight from the rules.
    task automatic modelLookup(input logic [4:0] rs, output logic hit, output logic [63:0] data);
        hit = 1'b0;
        data = 64'd0;
        if (!(c_DROP_X0 && rs == 5'd0)) begin
            for (int i = mRd.size() - 1; i >= 0; i--) begin
                if (mRd[i] == rs) begin
                    hit = 1'b1;
                    data = mData[i];
                    break;
                end
            end
        end
    endtask

    task automatic modelCheck();
        logic h; logic [63:0] d;
        int n;
        n = mRd.size();
        check("count", {61'd0, count}, 64'(n));
        check("in_ready", {63'd0, in_ready}, {63'd0, n != c_DEPTH});
        check("RegWrite", {63'd0, RegWrite}, {63'd0, (n != 0) && !wb_stall});
        check("RD", {59'd0, RD}, (n != 0) ? {59'd0, mRd[0]} : 64'd0);
        check("WriteData", WriteData, (n != 0) ? mData[0] : 64'd0);
        modelLookup(lk_rs1, h, d);
        check("lk_hit1", {63'd0, lk_hit1}, {63'd0, h});
        check("lk_data1", lk_data1, d);
        modelLookup(lk_rs2, h, d);
        check("lk_hit2", {63'd0, lk_hit2}, {63'd0, h});
        check("lk_data2", lk_data2, d);
    endtask

    // One clock: drive, check against the model, clock, advance the model.
    task automatic runCycle(input logic rst, input logic v, input logic [4:0] rd,
                            input logic [63:0] d, input logic st,
                            input logic [4:0] l1, input logic [4:0] l2);
        logic willPop, willAccept;
        drive(rst, v, rd, d, st, l1, l2);
        #2;
        modelCheck();
        willPop    = (mRd.size() != 0) && !st;
        willAccept = v && (mRd.size() != c_DEPTH);
        @(posedge clk);
        #1;
        if (!rst) begin
            mRd.delete();
            mData.delete();
        end else begin
            if (willPop) begin
                void'(mRd.pop_front());
                void'(mData.pop_front());
            end
            if (willAccept && !(c_DROP_X0 && rd == 5'd0)) begin
                mRd.push_back(rd);
                mData.push_back(d);
            end
        end
    endtask

    initial begin
        //        rst   vld   rd     data      st    l1     l2     rw    RD     WD        rdy   cnt   h1    d1        h2    d2
        vecs[0]  = '{1'b1, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 64'hAA, 1'b1, 3'd1, 1'b1, 64'hAA, 1'b0, 64'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[3]  = '{1'b1, 1'b1, 5'd1, 64'h11, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[4]  = '{1'b1, 1'b1, 5'd2, 64'h22, 1'b1, 5'd1, 5'd2, 1'b0, 5'd1, 64'h11, 1'b1, 3'd1, 1'b1, 64'h11, 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd2, 5'd3, 1'b0, 5'd1, 64'h11, 1'b1, 3'd2, 1'b1, 64'h22, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd3, 5'd4, 1'b0, 5'd1, 64'h11, 1'b1, 3'd3, 1'b1, 64'h33, 1'b0, 64'h0};
        vecs[7]  = '{1'b1, 1'b1, 5'd9, 64'h55, 1'b1, 5'd4, 5'd9, 1'b0, 5'd1, 64'h11, 1'b0, 3'd4, 1'b1, 64'h44, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, 1'b1, 5'd9, 64'h55, 1'b0, 5'd9, 5'd1, 1'b1, 5'd1, 64'h11, 1'b0, 3'd4, 1'b0, 64'h0,  1'b1, 64'h11};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd1, 5'd2, 1'b1, 5'd2, 64'h22, 1'b1, 3'd3, 1'b0, 64'h0,  1'b1, 64'h22};
        vecs[10] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 64'h33, 1'b1, 3'd2, 1'b1, 64'h33, 1'b1, 64'h44};
        vecs[11] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 64'h44, 1'b1, 3'd1, 1'b1, 64'h44, 1'b0, 64'h0};
        vecs[12] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[13] = '{1'b1, 1'b1, 5'd7, 64'h10, 1'b1, 5'd7, 5'd8, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[14] = '{1'b1, 1'b1, 5'd7, 64'h20, 1'b1, 5'd7, 5'd8, 1'b0, 5'd7, 64'h10, 1'b1, 3'd1, 1'b1, 64'h10, 1'b0, 64'h0};
        vecs[15] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 5'd8, 1'b0, 5'd7, 64'h10, 1'b1, 3'd2, 1'b1, 64'h20, 1'b0, 64'h0};
        vecs[16] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b1, 5'd7, 64'h10, 1'b1, 3'd2, 1'b1, 64'h20, 1'b0, 64'h0};
        vecs[17] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b1, 5'd7, 64'h20, 1'b1, 3'd1, 1'b1, 64'h20, 1'b0, 64'h0};
        vecs[18] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[19] = '{1'b1, 1'b1, 5'd0, 64'h99, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};
        vecs[20] = '{1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0,  1'b1, 3'd0, 1'b0, 64'h0,  1'b0, 64'h0};

        // Power-up reset.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;

        // Directed vector table; the queue is empty again after the last row.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].rd, vecs[i].data,
                  vecs[i].stall, vecs[i].l1, vecs[i].l2);
            #2;
            check($sformatf("v%0d_RegWrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].eRw});
            check($sformatf("v%0d_RD", i), {59'd0, RD}, {59'd0, vecs[i].eRd});
            check($sformatf("v%0d_WriteData", i), WriteData, vecs[i].eWd);
            check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].eRdy});
            check($sformatf("v%0d_count", i), {61'd0, count}, {61'd0, vecs[i].eCnt});
            check($sformatf("v%0d_lk_hit1", i), {63'd0, lk_hit1}, {63'd0, vecs[i].eH1});
            check($sformatf("v%0d_lk_data1", i), lk_data1, vecs[i].eD1);
            check($sformatf("v%0d_lk_hit2", i), {63'd0, lk_hit2}, {63'd0, vecs[i].eH2});
            check($sformatf("v%0d_lk_data2", i), lk_data2, vecs[i].eD2);
            @(posedge clk);
            #1;
        end

        // Steady-state push+drain at occupancy 2; pointers wrap twice.
        runCycle(1'b1, 1'b1, 5'd10, 64'h100, 1'b1, 5'd10, 5'd11);
        runCycle(1'b1, 1'b1, 5'd11, 64'h101, 1'b1, 5'd10, 5'd11);
        for (int i = 0; i < 6; i++) begin
            runCycle(1'b1, 1'b1, 5'(12 + i), 64'h200 + 64'(i), 1'b0, 5'(11 + i), 5'(10 + i));
            check("wrap_count", {61'd0, count}, 64'd2);
        end
        runCycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd16, 5'd17);
        runCycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd16, 5'd17);
        runCycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd16, 5'd17);

        // Reset with three pending entries and a concurrent push.
        runCycle(1'b1, 1'b1, 5'd20, 64'hA0, 1'b1, 5'd0, 5'd0);
        runCycle(1'b1, 1'b1, 5'd21, 64'hA1, 1'b1, 5'd0, 5'd0);
        runCycle(1'b1, 1'b1, 5'd22, 64'hA2, 1'b1, 5'd0, 5'd0);
        check("pre_reset_count", {61'd0, count}, 64'd3);
        runCycle(1'b0, 1'b1, 5'd23, 64'hA3, 1'b0, 5'd20, 5'd23);
        drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd23, 5'd20);
        #2;
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
        check("rst_lk_hit1", {63'd0, lk_hit1}, 64'd0);
        check("rst_lk_hit2", {63'd0, lk_hit2}, 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            logic r, v, s;
            logic [4:0] rd, l1, l2;
            r  = ($urandom_range(0, 59) != 0);
            v  = ($urandom_range(0, 9) < 6);
            s  = ($urandom_range(0, 9) < 4);
            rd = 5'($urandom_range(0, 7));
            l1 = 5'($urandom_range(0, 7));
            l2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            runCycle(r, v, rd, {$urandom, $urandom}, s, l1, l2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
